// File: rtl/axis_downsizer_if.sv
// AXI-Stream bundle for the width down-converter: one beat of BYTES bytes with
// strobes, end-of-packet marker and the valid/ready pair.
`timescale 1ns/1ps
interface axis_downsizer_if #(
   parameter int BYTES = 2
) ();
   // A beat transfers on a rising clock edge where tvalid and tready are both 1;
   // once tvalid is raised the master holds tdata/tkeep/tlast until that edge.
   logic               tvalid;
   logic               tready;
   logic               tlast;
   logic [8*BYTES-1:0] tdata;
   logic [BYTES-1:0]   tkeep;

   modport master (output tvalid, tlast, tdata, tkeep, input tready);
   modport slave  (input tvalid, tlast, tdata, tkeep, output tready);
endinterface

// File: rtl/axis_downsizer.sv
// AXI-Stream width down-converter: splits one RATIO*OUT_BYTES-byte beat into up to
// RATIO narrow beats, dropping trailing all-empty slices of a tlast beat.
`timescale 1ns/1ps
module axis_downsizer #(
   parameter int OUT_BYTES = 2,
   parameter int RATIO     = 2,
   parameter int LSB_FIRST = 1,
   parameter int KEEP_EN   = 1
) (
   input logic               axis_clk,
   input logic               axis_rst,
   axis_downsizer_if.slave   axis_in,
   axis_downsizer_if.master  axis_out
);
   localparam int IN_BYTES = OUT_BYTES * RATIO;
   localparam int OW       = 8 * OUT_BYTES;
   localparam int IDX_W    = $clog2(RATIO);

   logic [8*IN_BYTES-1:0] r_data;
   logic [IN_BYTES-1:0]   r_keep;
   logic                  r_last;
   logic [IDX_W-1:0]      r_idx;
   logic [IDX_W-1:0]      r_end_idx;
   logic                  r_full;
   logic                  r_rdy_en;

   logic [IDX_W-1:0]      w_phys;
   logic [IDX_W-1:0]      w_load_end;
   logic                  w_final;
   logic                  w_in_hs;
   logic                  w_out_hs;

   // Emission order index to physical slice position.
   function automatic int phys_of(input int e);
      return (LSB_FIRST != 0) ? e : (RATIO - 1 - e);
   endfunction

   always_comb begin
      w_load_end = IDX_W'(RATIO - 1);
      if ((KEEP_EN != 0) && axis_in.tlast) begin
         w_load_end = '0;
         for (int e = 0; e < RATIO; e++) begin
            if (|axis_in.tkeep[phys_of(e)*OUT_BYTES +: OUT_BYTES]) begin
               w_load_end = IDX_W'(e);
            end
         end
      end
   end

   assign w_phys   = IDX_W'(phys_of(int'(r_idx)));
   assign w_final  = (r_idx == r_end_idx);
   assign w_out_hs = r_full & axis_out.tready;
   // Ready is held low until the first clock after reset release.
   assign axis_in.tready = r_rdy_en & (~r_full | (axis_out.tready & w_final));
   assign w_in_hs  = axis_in.tvalid & axis_in.tready;

   assign axis_out.tvalid = r_full;
   assign axis_out.tlast  = r_full & r_last & w_final;
   assign axis_out.tdata  = r_full ? r_data[w_phys*OW +: OW] : '0;
   assign axis_out.tkeep  = r_full ? r_keep[w_phys*OUT_BYTES +: OUT_BYTES] : '0;

   always_ff @(posedge axis_clk or negedge axis_rst) begin
      if (!axis_rst) begin
         r_data    <= '0;
         r_keep    <= '0;
         r_last    <= 1'b0;
         r_idx     <= '0;
         r_end_idx <= '0;
         r_full    <= 1'b0;
         r_rdy_en  <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
         if (w_out_hs) begin
            if (!w_final) begin
               r_idx <= r_idx + IDX_W'(1);
            end else begin
               r_full <= 1'b0;
            end
         end
         // A load on the final-slice handshake overrides the clear above.
         if (w_in_hs) begin
            r_data    <= axis_in.tdata;
            r_keep    <= axis_in.tkeep;
            r_last    <= axis_in.tlast;
            r_idx     <= '0;
            r_end_idx <= w_load_end;
            r_full    <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_axis_downsizer.sv
// Bench for axis_downsizer: four parameter sets, directed vector table, random
// streams checked against a slice-level reference model, and async reset mid-beat.
`timescale 1ns/1ps
module tb_axis_downsizer;
   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // per-DUT drive and observe arrays (0:A 2x2 lsb, 1:B 2x2 msb, 2:C 1x4 keep, 3:D 1x4 nokeep)
   logic        i_valid [4];
   logic        i_last  [4];
   logic [31:0] i_data  [4];
   logic [3:0]  i_keep  [4];
   logic        o_ready [4];
   logic        in_rdy  [4];
   logic        o_valid [4];
   logic        o_last  [4];
   logic [15:0] o_data  [4];
   logic [1:0]  o_keep  [4];

   axis_downsizer_if #(.BYTES(4)) in_a ();
   axis_downsizer_if #(.BYTES(2)) out_a ();
   axis_downsizer_if #(.BYTES(4)) in_b ();
   axis_downsizer_if #(.BYTES(2)) out_b ();
   axis_downsizer_if #(.BYTES(4)) in_c ();
   axis_downsizer_if #(.BYTES(1)) out_c ();
   axis_downsizer_if #(.BYTES(4)) in_d ();
   axis_downsizer_if #(.BYTES(1)) out_d ();

   assign in_a.tvalid = i_valid[0];  assign in_a.tlast = i_last[0];
   assign in_a.tdata  = i_data[0];   assign in_a.tkeep = i_keep[0];
   assign out_a.tready = o_ready[0]; assign in_rdy[0] = in_a.tready;
   assign o_valid[0] = out_a.tvalid; assign o_last[0] = out_a.tlast;
   assign o_data[0]  = out_a.tdata;  assign o_keep[0] = out_a.tkeep;

   assign in_b.tvalid = i_valid[1];  assign in_b.tlast = i_last[1];
   assign in_b.tdata  = i_data[1];   assign in_b.tkeep = i_keep[1];
   assign out_b.tready = o_ready[1]; assign in_rdy[1] = in_b.tready;
   assign o_valid[1] = out_b.tvalid; assign o_last[1] = out_b.tlast;
   assign o_data[1]  = out_b.tdata;  assign o_keep[1] = out_b.tkeep;

   assign in_c.tvalid = i_valid[2];  assign in_c.tlast = i_last[2];
   assign in_c.tdata  = i_data[2];   assign in_c.tkeep = i_keep[2];
   assign out_c.tready = o_ready[2]; assign in_rdy[2] = in_c.tready;
   assign o_valid[2] = out_c.tvalid; assign o_last[2] = out_c.tlast;
   assign o_data[2]  = {8'h00, out_c.tdata}; assign o_keep[2] = {1'b0, out_c.tkeep};

   assign in_d.tvalid = i_valid[3];  assign in_d.tlast = i_last[3];
   assign in_d.tdata  = i_data[3];   assign in_d.tkeep = i_keep[3];
   assign out_d.tready = o_ready[3]; assign in_rdy[3] = in_d.tready;
   assign o_valid[3] = out_d.tvalid; assign o_last[3] = out_d.tlast;
   assign o_data[3]  = {8'h00, out_d.tdata}; assign o_keep[3] = {1'b0, out_d.tkeep};

   axis_downsizer #(.OUT_BYTES(2), .RATIO(2), .LSB_FIRST(1), .KEEP_EN(1)) dut_a (
      .axis_clk(clk), .axis_rst(rst_n), .axis_in(in_a), .axis_out(out_a));
   axis_downsizer #(.OUT_BYTES(2), .RATIO(2), .LSB_FIRST(0), .KEEP_EN(1)) dut_b (
      .axis_clk(clk), .axis_rst(rst_n), .axis_in(in_b), .axis_out(out_b));
   axis_downsizer #(.OUT_BYTES(1), .RATIO(4), .LSB_FIRST(1), .KEEP_EN(1)) dut_c (
      .axis_clk(clk), .axis_rst(rst_n), .axis_in(in_c), .axis_out(out_c));
   axis_downsizer #(.OUT_BYTES(1), .RATIO(4), .LSB_FIRST(1), .KEEP_EN(0)) dut_d (
      .axis_clk(clk), .axis_rst(rst_n), .axis_in(in_d), .axis_out(out_d));

   // ---------------- scoreboard ----------------
   // entry: {final_slice_of_beat, tlast, tkeep[3:0], tdata[15:0]}
   logic [21:0] exp_q[$];
   int checks = 0;
   int failures = 0;
   int cur = 0;
   bit mon_en = 1'b0;
   bit idle_chk = 1'b0;
   bit rand_rdy = 1'b0;
   bit chk_rdy = 1'b0;

   typedef struct {
      int          dut;
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      int          n;
      logic [3:0][20:0] e;
   } vec_t;
   vec_t vecs[9];

   function automatic logic [20:0] mk(input logic l, input logic [3:0] k, input logic [15:0] dt);
      return {l, k, dt};
   endfunction

   function automatic vec_t mkv(input int d, input logic [31:0] data, input logic [3:0] keep,
                                input logic last, input int n, input logic [20:0] e0,
                                input logic [20:0] e1, input logic [20:0] e2, input logic [20:0] e3);
      vec_t v;
      v.dut = d; v.data = data; v.keep = keep; v.last = last; v.n = n;
      v.e = {e3, e2, e1, e0};
      return v;
   endfunction

   // Reference: the beat is cut into RATIO slices in emission order; a tlast beat with
   // keep enabled stops after the last slice that carries any byte (at least one slice).
   function automatic void push_model(input int d, input logic [31:0] data,
                                      input logic [3:0] keep, input logic last);
      int ob, r, n, p;
      bit lsb, ken;
      logic [31:0] sd, sk;
      ob  = (d < 2) ? 2 : 1;
      r   = (d < 2) ? 2 : 4;
      lsb = (d != 1);
      ken = (d != 3);
      n = r;
      if (ken && last) begin
         n = 1;
         for (int e = 0; e < r; e++) begin
            p = lsb ? e : r - 1 - e;
            if (((32'(keep) >> (p * ob)) & ((32'd1 << ob) - 1)) != 0) n = e + 1;
         end
      end
      for (int e = 0; e < n; e++) begin
         p  = lsb ? e : r - 1 - e;
         sd = (data >> (p * 8 * ob)) & ((32'd1 << (8 * ob)) - 1);
         sk = (32'(keep) >> (p * ob)) & ((32'd1 << ob) - 1);
         exp_q.push_back({(e == n - 1), last && (e == n - 1), sk[3:0], sd[15:0]});
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s dut=%0d actual=%h required=%h t=%0t", name, cur, act, req, $time);
      end
   endtask

   task automatic monitor();
      logic [21:0] e;
      if (!mon_en) return;
      if (o_valid[cur] && o_ready[cur]) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL extra_beat dut=%0d actual=%h required=none t=%0t", cur,
                     {o_last[cur], 2'b00, o_keep[cur], o_data[cur]}, $time);
         end else begin
            e = exp_q.pop_front();
            check("out_beat", {11'h0, o_last[cur], 2'b00, o_keep[cur], o_data[cur]}, {11'h0, e[20:0]});
            if (chk_rdy) check("in_ready_final", {31'h0, in_rdy[cur]}, {31'h0, e[21]});
         end
      end
      if (idle_chk && exp_q.size() != 0 && !o_valid[cur]) check("idle_cycle", 32'(o_valid[cur]), 32'd1);
   endtask

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      if (rand_rdy) o_ready[cur] = 1'($urandom_range(0, 1));
   endtask

   task automatic send(input int d, input logic [31:0] data, input logic [3:0] keep,
                       input logic last, input bit hold);
      bit hs, ok;
      ok = 1'b0;
      i_valid[d] = 1'b1; i_data[d] = data; i_keep[d] = keep; i_last[d] = last;
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         monitor();
         hs = in_rdy[d];
         @(posedge clk);
         #1;
         if (rand_rdy) o_ready[cur] = 1'($urandom_range(0, 1));
         if (hs) begin ok = 1'b1; break; end
      end
      if (!hold) i_valid[d] = 1'b0;
      if (!ok) check("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int t = 0; t < 400; t++) begin
         if (exp_q.size() == 0) break;
         step();
      end
      if (exp_q.size() != 0) begin
         check("drain_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
      repeat (3) step();
   endtask

   task automatic run_vec(input vec_t v);
      cur = v.dut;
      o_ready[v.dut] = 1'b1;
      for (int k = 0; k < v.n; k++) exp_q.push_back({(k == v.n - 1), v.e[k]});
      send(v.dut, v.data, v.keep, v.last, 1'b0);
      check("latency_valid", 32'(o_valid[v.dut]), 32'd1);
      drain();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- test sequence ----------------
   initial begin
      logic [31:0] rd;
      logic [3:0]  rk;
      logic        rl;
      for (int d = 0; d < 4; d++) begin
         i_valid[d] = 1'b0; i_last[d] = 1'b0; i_data[d] = '0; i_keep[d] = '0; o_ready[d] = 1'b0;
      end
      vecs[0] = mkv(0, 32'hAABBCCDD, 4'hF, 1'b0, 2, mk(0,3,16'hCCDD), mk(0,3,16'hAABB), 0, 0);
      vecs[1] = mkv(1, 32'hAABBCCDD, 4'hF, 1'b0, 2, mk(0,3,16'hAABB), mk(0,3,16'hCCDD), 0, 0);
      vecs[2] = mkv(2, 32'h000000EE, 4'h1, 1'b1, 1, mk(1,1,16'h00EE), 0, 0, 0);
      vecs[3] = mkv(3, 32'h000000EE, 4'h1, 1'b1, 4, mk(0,1,16'h00EE), mk(0,0,16'h0000),
                    mk(0,0,16'h0000), mk(1,0,16'h0000));
      vecs[4] = mkv(0, 32'h12345678, 4'h0, 1'b1, 1, mk(1,0,16'h5678), 0, 0, 0);
      vecs[5] = mkv(1, 32'h12345678, 4'h0, 1'b1, 1, mk(1,0,16'h1234), 0, 0, 0);
      vecs[6] = mkv(2, 32'h11223344, 4'h6, 1'b1, 3, mk(0,0,16'h0044), mk(0,1,16'h0033),
                    mk(1,1,16'h0022), 0);
      vecs[7] = mkv(1, 32'hAABBCCDD, 4'h3, 1'b1, 2, mk(0,0,16'hAABB), mk(1,3,16'hCCDD), 0, 0);
      vecs[8] = mkv(3, 32'h11223344, 4'h0, 1'b1, 4, mk(0,0,16'h0044), mk(0,0,16'h0033),
                    mk(0,0,16'h0022), mk(1,0,16'h0011));

      // reset state
      repeat (3) step();
      for (int d = 0; d < 4; d++) begin
         cur = d;
         check("rst_valid", 32'(o_valid[d]), 32'd0);
         check("rst_in_ready", 32'(in_rdy[d]), 32'd0);
         check("rst_data", 32'(o_data[d]), 32'd0);
      end
      rst_n = 1'b1;
      #1;
      cur = 0;
      check("rel_in_ready_pre", 32'(in_rdy[0]), 32'd0);
      step();
      for (int d = 0; d < 4; d++) begin
         cur = d;
         check("rel_in_ready_post", 32'(in_rdy[d]), 32'd1);
      end
      mon_en = 1'b1;

      // directed vector table
      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // continuous valid/ready, random beats
      cur = 2;
      o_ready[2] = 1'b1;
      chk_rdy = 1'b1;
      for (int i = 0; i < 100; i++) begin
         rd = $urandom; rk = 4'($urandom_range(0, 15)); rl = 1'($urandom_range(0, 1));
         push_model(2, rd, rk, rl);
         send(2, rd, rk, rl, 1'b1);
         if (i == 0) idle_chk = 1'b1;
      end
      i_valid[2] = 1'b0;
      drain();
      idle_chk = 1'b0;
      chk_rdy = 1'b0;

      // random output stalls on the 2x2 lsb-first instance
      cur = 0;
      rand_rdy = 1'b1;
      for (int i = 0; i < 30; i++) begin
         rd = $urandom; rk = 4'($urandom_range(0, 15)); rl = 1'($urandom_range(0, 1));
         push_model(0, rd, rk, rl);
         send(0, rd, rk, rl, 1'($urandom_range(0, 1)));
      end
      i_valid[0] = 1'b0;
      drain();

      // asynchronous reset in the middle of a beat
      rand_rdy = 1'b0;
      mon_en = 1'b0;
      o_ready[0] = 1'b0;
      send(0, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0);
      step();
      o_ready[0] = 1'b1;
      step();
      o_ready[0] = 1'b0;
      check("mid_valid", 32'(o_valid[0]), 32'd1);
      check("mid_data", 32'(o_data[0]), 32'h0000DEAD);
      check("mid_last", 32'(o_last[0]), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_valid", 32'(o_valid[0]), 32'd0);
      check("async_data", 32'(o_data[0]), 32'd0);
      check("async_keep", 32'(o_keep[0]), 32'd0);
      check("async_last", 32'(o_last[0]), 32'd0);
      check("async_in_ready", 32'(in_rdy[0]), 32'd0);
      step();
      step();
      check("rst_hold_in_ready", 32'(in_rdy[0]), 32'd0);
      rst_n = 1'b1;
      step();
      check("rerel_in_ready", 32'(in_rdy[0]), 32'd1);
      exp_q.delete();
      mon_en = 1'b1;
      rand_rdy = 1'b1;
      push_model(0, 32'h55667788, 4'hF, 1'b1);
      send(0, 32'h55667788, 4'hF, 1'b1, 1'b0);
      drain();
      rand_rdy = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
